// File: rtl/ysyx_22040759_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040759_req_arbiter_pkg
// Shared definitions for the memory-request arbiter:
//   - FSM state encodings (ARB_IDLE / ARB_BUSY / ARB_RESP), 2-bit
//   - downstream response codes (RESP_OKAY / RESP_SLVERR)
//   - arbitration mode selectors for the PRIO_MODE parameter
// ---------------------------------------------------------------------------
package ysyx_22040759_req_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 2'b00;
    localparam arb_state_t ARB_BUSY = 2'b01;
    localparam arb_state_t ARB_RESP = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned PRIO_FIXED = 0;
    localparam int unsigned PRIO_RR    = 1;

endpackage

// File: rtl/ysyx_22040759_rr_pick.sv
// ---------------------------------------------------------------------------
// ysyx_22040759_rr_pick
// Purely combinational one-hot grant selector.
//   i_req   : request vector, bit i = channel i
//   i_ptr   : round-robin start index (ignored in fixed mode)
//   i_mode  : 0 = fixed priority (lowest index wins), 1 = round-robin
//   o_grant : one-hot grant, all-zero when no request is present
// ---------------------------------------------------------------------------
module ysyx_22040759_rr_pick #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned PTR_W  = 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    input  logic              i_mode,
    output logic [NUM_CH-1:0] o_grant
);

    logic [PTR_W-1:0]    w_start;
    logic [2*NUM_CH-1:0] w_req2;
    logic [2*NUM_CH-1:0] w_rot;
    logic [NUM_CH-1:0]   w_rot_oh;
    logic [2*NUM_CH-1:0] w_unrot;
    logic                w_found;

    assign w_start = i_mode ? i_ptr : '0;
    assign w_req2  = {i_req, i_req};
    // Rotating the doubled vector right by the start index makes the
    // wrap-around search a plain lowest-set-bit search.
    assign w_rot   = w_req2 >> w_start;

    always_comb begin
        w_rot_oh = '0;
        w_found  = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (w_rot[k] && !w_found) begin
                w_rot_oh[k] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    // Rotate back: bits pushed past NUM_CH-1 fold onto the low end.
    assign w_unrot = {{NUM_CH{1'b0}}, w_rot_oh} << w_start;
    assign o_grant = w_unrot[NUM_CH-1:0] | w_unrot[2*NUM_CH-1:NUM_CH];

endmodule

// File: rtl/ysyx_22040759_req_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22040759_req_arbiter
// N-channel memory-request arbiter in front of the single AXI bridge port.
// One outstanding transaction; grant and request fields are latched in IDLE,
// presented in BUSY, and completion is returned as a one-cycle ch_ready pulse
// in RESP. Fixed-priority or round-robin selection via PRIO_MODE.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : BUSY is abandoned after TIMEOUT_CYC cycles without out_ready,
//               completing with resp = SLVERR and rdata = 0.
//   undefined : BUSY waits indefinitely.
//
// Ports:
//   clock, reset            clock / asynchronous active-high reset
//   ch_valid/req/addr/...   per-channel request inputs (packed lanes)
//   ch_ready/rdata/resp     per-channel completion outputs (packed lanes)
//   out_valid/req/addr/...  downstream request (latched fields)
//   out_ready/rdata/resp    downstream completion inputs
//   busy                    high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module ysyx_22040759_req_arbiter
    import ysyx_22040759_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned PRIO_MODE   = 0,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    input  logic [NUM_CH*2-1:0]        ch_size,
    output logic [NUM_CH-1:0]          ch_ready,
    output logic [NUM_CH*DATA_W-1:0]   ch_rdata,
    output logic [NUM_CH*2-1:0]        ch_resp,
    output logic                       out_valid,
    output logic                       out_req,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_wdata,
    output logic [1:0]                 out_size,
    input  logic                       out_ready,
    input  logic [DATA_W-1:0]          out_rdata,
    input  logic [1:0]                 out_resp,
    output logic                       busy
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_t                r_state;
    logic [NUM_CH-1:0]         r_grant;
    logic [PTR_W-1:0]          r_rr_ptr;
    logic                      r_out_valid;
    logic                      r_out_req;
    logic [ADDR_W-1:0]         r_out_addr;
    logic [DATA_W-1:0]         r_out_wdata;
    logic [1:0]                r_out_size;
    logic [NUM_CH-1:0]         r_ch_ready;
    logic [NUM_CH*DATA_W-1:0]  r_ch_rdata;
    logic [NUM_CH*2-1:0]       r_ch_resp;

    logic [NUM_CH-1:0]         w_grant;
    logic                      w_rr_mode;
    logic                      w_sel_req;
    logic [ADDR_W-1:0]         w_sel_addr;
    logic [DATA_W-1:0]         w_sel_wdata;
    logic [1:0]                w_sel_size;
    logic [PTR_W-1:0]          w_next_ptr;
    logic                      w_timeout;
    logic                      w_done;
    logic [DATA_W-1:0]         w_cap_rdata;
    logic [1:0]                w_cap_resp;

    assign w_rr_mode = (PRIO_MODE == PRIO_RR);

    ysyx_22040759_rr_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_pick (
        .i_req   (ch_valid),
        .i_ptr   (r_rr_ptr),
        .i_mode  (w_rr_mode),
        .o_grant (w_grant)
    );

    // One-hot mux of the winning channel's request fields.
    always_comb begin
        w_sel_req   = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_size  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_sel_req   = ch_req[i];
                w_sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
                w_sel_size  = ch_size[i*2 +: 2];
            end
        end
    end

    // Pointer to the channel after the current grant, wrapping to 0.
    always_comb begin
        w_next_ptr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (r_grant[i] && (i != NUM_CH - 1)) begin
                w_next_ptr = PTR_W'(i + 1);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // Cleared while idle so every BUSY entry starts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state != ARB_BUSY) begin
            r_cnt <= '0;
        end else if (!out_ready && !w_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ARB_BUSY) && (r_cnt == CNT_W'(TIMEOUT_CYC));
`else
    assign w_timeout = 1'b0;
`endif

    // A real completion wins over a timeout reached in the same cycle.
    assign w_done      = out_ready || w_timeout;
    assign w_cap_rdata = out_ready ? out_rdata : '0;
    assign w_cap_resp  = out_ready ? out_resp  : RESP_SLVERR;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_req   <= 1'b0;
            r_out_addr  <= '0;
            r_out_wdata <= '0;
            r_out_size  <= '0;
            r_ch_ready  <= '0;
            r_ch_rdata  <= '0;
            r_ch_resp   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_ch_ready <= '0;
                    if (|ch_valid) begin
                        r_grant     <= w_grant;
                        r_out_valid <= 1'b1;
                        r_out_req   <= w_sel_req;
                        r_out_addr  <= w_sel_addr;
                        r_out_wdata <= w_sel_wdata;
                        r_out_size  <= w_sel_size;
                        r_state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (w_done) begin
                        r_out_valid <= 1'b0;
                        r_ch_ready  <= r_grant;
                        // Only the granted lane is rewritten; others hold.
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (r_grant[i]) begin
                                r_ch_rdata[i*DATA_W +: DATA_W] <= w_cap_rdata;
                                r_ch_resp[i*2 +: 2]            <= w_cap_resp;
                            end
                        end
                        r_state <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    r_ch_ready <= '0;
                    if (w_rr_mode) begin
                        r_rr_ptr <= w_next_ptr;
                    end
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign ch_ready  = r_ch_ready;
    assign ch_rdata  = r_ch_rdata;
    assign ch_resp   = r_ch_resp;
    assign out_valid = r_out_valid;
    assign out_req   = r_out_req;
    assign out_addr  = r_out_addr;
    assign out_wdata = r_out_wdata;
    assign out_size  = r_out_size;
    assign busy      = (r_state != ARB_IDLE);

endmodule

// File: doc/ysyx_22040759_req_arbiter.md
# ysyx_22040759_req_arbiter

Parametrised N-channel memory-request arbiter between the core's requesters (instruction fetch, data memory, and future requesters such as a cache refill or DMA) and the single shared request port of the AXI bridge. It replaces the fixed two-port IF/MEM wiring with one registered grant, selectable in parameter between fixed-priority and round-robin arbitration. It supports exactly one outstanding transaction and has an optional timeout watchdog.

## Interface
Parameters:
- NUM_CH, 2: number of requesting channels (≥2); channel 0 has highest fixed priority.
- ADDR_W, 64: address width.
- DATA_W, 64: data width.
- PRIO_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYC, 255: watchdog limit in cycles; used only with the timeout macro defined.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ch_valid  in  NUM_CH  per-channel request valid, held high until that channel's ready.
- ch_req  in  NUM_CH  per-channel request type: 0 = read, 1 = write.
- ch_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  packed write data.
- ch_size  in  NUM_CH*2  packed transfer size (00 = B, 01 = H, 10 = W, 11 = D).
- ch_ready  out  NUM_CH  one-cycle completion pulse, one-hot.
- ch_rdata  out  NUM_CH*DATA_W  packed read data; valid while the matching ch_ready is high.
- ch_resp  out  NUM_CH*2  packed response code; valid while the matching ch_ready is high.
- out_valid  out  1  downstream request valid.
- out_req, out_addr, out_wdata, out_size  out  1/ADDR_W/DATA_W/2  latched request of the granted channel.
- out_ready  in  1  downstream completion pulse.
- out_rdata  in  DATA_W  downstream read data, sampled with out_ready.
- out_resp  in  2  downstream response, sampled with out_ready.
- busy  out  1  high in every state other than IDLE.

## Operation
- State machine: IDLE → BUSY → RESP → IDLE. State encodings are 2-bit.
- IDLE:
  - If any ch_valid is high, pick one channel: fixed mode takes the lowest index; round-robin mode searches upward from rr_ptr with wrap-around.
  - Latch the grant (one-hot) and that channel's req/addr/wdata/size, then go to BUSY.
  - If no ch_valid is high, stay in IDLE.
- BUSY:
  - out_valid = 1 with the latched fields, all stable.
  - When out_ready is sampled high, capture out_rdata/out_resp and go to RESP.
- RESP:
  - Pulse ch_ready[grant] for exactly one cycle. ch_rdata/ch_resp for the granted lane carry the captured values; all other lanes hold their previous values.
  - Set rr_ptr = (grant index + 1) mod NUM_CH, wrapping at NUM_CH−1 → 0. rr_ptr is updated only in round-robin mode.
  - Go to IDLE.
- Requester rule: a channel deasserts ch_valid at the same edge at which it samples ch_ready, so it is never re-granted for a completed request.
- ch_valid deasserted by a requester while that channel is granted is ignored; the latched request still completes.
- Changes on non-granted channels never affect an in-flight transaction.
- Reset, including mid-transaction: state = IDLE, rr_ptr = 0, grant = 0, and every output = 0. The downstream transaction is abandoned; the bridge shares the same reset.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Minimum latency is 3 cycles from ch_valid high at edge 0 to the ch_ready pulse:
  - edge 0: grant latched;
  - cycle 1: out_valid = 1;
  - out_ready high in cycle k → ch_ready high in cycle k+1.
- out_valid falls the cycle after out_ready is sampled.
- Back-to-back: the next grant is decided in the IDLE cycle that follows RESP, so there is a 1-cycle bubble between transactions.
- Simultaneous requests in IDLE resolve within that same cycle; the losers wait with ch_valid held.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter in BUSY increments each cycle while out_ready is low and clears on entry to BUSY.
  - On reaching TIMEOUT_CYC, go to RESP with resp = 2'b10 (SLVERR) and rdata = 0, and drop out_valid.
  - out_ready sampled in the same cycle as the limit takes precedence: normal completion.
- ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely and TIMEOUT_CYC is unused.

## Structure
- The shared define file holds the state encodings (ARB_IDLE/ARB_BUSY/ARB_RESP) and the response codes RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
- Sub-module ysyx_22040759_rr_pick is purely combinational:
  - inputs: request vector, start pointer, mode;
  - output: one-hot grant.
  - It is instantiated once.

## Test plan
- Single read: ch0 valid, addr 0x8000_0000; out_ready pulses 2 cycles after out_valid with rdata 0x1234 → ch_ready[0] pulses exactly 1 cycle with rdata 0x1234, resp 00; 5 cycles total.
- Contention, PRIO_MODE = 0: ch0 and ch1 held valid for 4 transactions → every grant goes to ch0; ch1 is granted only after ch0 drops.
- Contention, PRIO_MODE = 1, NUM_CH = 3: all three channels continuously valid → grant order 0,1,2,0,1,2, with rr_ptr wrapping from 2 to 0.
- Write with ch1 addr/wdata changing while granted → out_addr/out_wdata remain the values latched at grant.
- reset asserted asynchronously mid-BUSY → out_valid, busy, and ch_ready go to 0 immediately; after release, the first grant follows rr_ptr = 0.
- ARB_TIMEOUT_EN with TIMEOUT_CYC = 8 and out_ready never asserted → ch_ready pulses with resp 2'b10 and rdata 0, 10 cycles after grant.
